// File: rtl/digit_column_stream_sequencer_if.sv
// Pixel byte stream from the column sequencer to the display transport.
// A byte transfers on any clock edge where out_valid and out_ready are both high.
interface digit_column_stream_sequencer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_sop;
   logic       out_eop;

   modport master (output out_data, out_valid, out_sop, out_eop, input out_ready);
   modport slave  (input out_data, out_valid, out_sop, out_eop, output out_ready);
endinterface

// File: rtl/digit_column_stream_sequencer.sv
// Walks the segment-to-pixel decoder over every page/digit/column of one frame
// and streams the resulting pixel columns in SSD1306 page-addressing order.
module digit_column_stream_sequencer #(
   parameter int NUM_DIGITS = 6,
   parameter int SEG_W      = 7,
   parameter int CHAR_COLS  = 16,
   parameter int PAGES      = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [NUM_DIGITS*SEG_W-1:0] segs_in,
   output logic                        busy,
   output logic                        done,
   output logic [SEG_W-1:0]            dec_segments,
   output logic [3:0]                  dec_index_x,
   output logic [1:0]                  dec_index_y,
   input  logic [7:0]                  dec_pixels,
   digit_column_stream_sequencer_if.master stream,
   output logic [1:0]                  dbg_state
);

   localparam int COL_W  = $clog2(CHAR_COLS);
   localparam int DIG_W  = $clog2(NUM_DIGITS);
   localparam int PAGE_W = $clog2(PAGES);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(CHAR_COLS - 1);
   localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
   localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } state_t;

   state_t                      state;
   logic [COL_W-1:0]            col;
   logic [DIG_W-1:0]            dig;
   logic [PAGE_W-1:0]           page;
   logic [NUM_DIGITS*SEG_W-1:0] snap;
   logic                        last_byte;
   logic                        handshake;

   assign last_byte = (page == PAGE_LAST) && (dig == DIG_LAST) && (col == COL_LAST);
   assign handshake = stream.out_valid && stream.out_ready;

   // The decoder is combinational, so its inputs come straight from the counters.
   assign dec_index_x  = 4'(col);
   assign dec_index_y  = 2'(page);
   assign dec_segments = snap[int'(dig)*SEG_W +: SEG_W];
   assign dbg_state    = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         col              <= '0;
         dig              <= '0;
         page             <= '0;
         snap             <= '0;
         stream.out_data  <= '0;
         stream.out_valid <= 1'b0;
         stream.out_sop   <= 1'b0;
         stream.out_eop   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  snap  <= segs_in;
                  col   <= '0;
                  dig   <= '0;
                  page  <= '0;
                  busy  <= 1'b1;
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  stream.out_data  <= dec_pixels;
                  stream.out_sop   <= (dig == '0) && (col == '0);
                  stream.out_eop   <= (dig == DIG_LAST) && (col == COL_LAST);
                  stream.out_valid <= 1'b1;
                  state            <= SEND;
               end
            end
            SEND: begin
               // Abort beats a handshake landing on the same edge.
               if (abort) begin
                  stream.out_valid <= 1'b0;
                  busy             <= 1'b0;
                  state            <= IDLE;
               end else if (handshake) begin
                  stream.out_valid <= 1'b0;
                  if (last_byte) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= FETCH;
                     if (col == COL_LAST) begin
                        col <= '0;
                        if (dig == DIG_LAST) begin
                           dig  <= '0;
                           page <= page + 1'b1;
                        end else begin
                           dig <= dig + 1'b1;
                        end
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end
            end
            default: begin
               stream.out_valid <= 1'b0;
               busy             <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_column_stream_sequencer.sv
// Bench for digit_column_stream_sequencer: a toy decoder tags every byte with its
// page/column/segment word so the stream order can be checked against plain arithmetic.
module tb_digit_column_stream_sequencer;
   localparam int NUM_DIGITS = 6;
   localparam int SEG_W      = 7;
   localparam int CHAR_COLS  = 16;
   localparam int PAGES      = 4;
   localparam int PAGE_BYTES = NUM_DIGITS * CHAR_COLS;
   localparam int FRAME      = PAGES * PAGE_BYTES;
   localparam int SW         = NUM_DIGITS * SEG_W;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic          abort;
   logic [SW-1:0] segs_in;
   logic          busy;
   logic          done;
   logic [6:0]    dec_segments;
   logic [3:0]    dec_index_x;
   logic [1:0]    dec_index_y;
   logic [7:0]    dec_pixels;
   logic [1:0]    dbg_state;

   digit_column_stream_sequencer_if sif();

   digit_column_stream_sequencer #(
      .NUM_DIGITS(NUM_DIGITS), .SEG_W(SEG_W), .CHAR_COLS(CHAR_COLS), .PAGES(PAGES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .segs_in(segs_in),
      .busy(busy), .done(done), .dec_segments(dec_segments), .dec_index_x(dec_index_x),
      .dec_index_y(dec_index_y), .dec_pixels(dec_pixels), .stream(sif), .dbg_state(dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb dec_pixels = {dec_index_y, dec_index_x, 2'b00} ^ {1'b0, dec_segments};

   // Scoreboard state
   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_data[$];
   logic       got_sop[$];
   logic       got_eop[$];
   logic [3:0] got_x[$];
   logic [1:0] got_y[$];
   logic [6:0] got_seg[$];
   int stab_err, done_cnt, done_gap, first_hs, last_hs, valid_after_done;
   bit timed_out;

   // Reference: byte k of a frame is page k/96, digit (k/16)%6, column k%16.
   function automatic int model_errors(input logic [SW-1:0] snap);
      int errs = 0;
      for (int k = 0; k < got_data.size(); k++) begin
         int pg, dg, cl;
         logic [1:0] ey;
         logic [3:0] ex;
         logic [6:0] es;
         logic [7:0] ed;
         pg = k / PAGE_BYTES;
         dg = (k / CHAR_COLS) % NUM_DIGITS;
         cl = k % CHAR_COLS;
         ey = 2'(pg);
         ex = 4'(cl);
         es = snap[dg*SEG_W +: SEG_W];
         ed = {ey, ex, 2'b00} ^ {1'b0, es};
         if (got_data[k] !== ed || got_x[k] !== ex || got_y[k] !== ey || got_seg[k] !== es ||
             got_sop[k] !== (dg == 0 && cl == 0) ||
             got_eop[k] !== (dg == NUM_DIGITS-1 && cl == CHAR_COLS-1))
            errs++;
      end
      return errs;
   endfunction

   // Driver tasks
   task automatic start_frame(input logic [SW-1:0] s);
      @(negedge clk);
      segs_in = s;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic run_stream(input int ready_pct, input int stop_after, input bit disturb,
                             input int max_cycles);
      logic       hold = 1'b0;
      logic [7:0] pd = '0;
      logic       ps = 1'b0, pe = 1'b0;
      bit         seen_done = 0;
      int         post = 0;
      got_data.delete(); got_sop.delete(); got_eop.delete();
      got_x.delete(); got_y.delete(); got_seg.delete();
      stab_err = 0; done_cnt = 0; done_gap = -1; first_hs = -1; last_hs = -1;
      valid_after_done = 0; timed_out = 1;
      for (int cyc = 0; cyc < max_cycles; cyc++) begin
         @(negedge clk);
         if (hold && (sif.out_valid !== 1'b1 || sif.out_data !== pd ||
                      sif.out_sop !== ps || sif.out_eop !== pe))
            stab_err++;
         if (done === 1'b1) begin
            done_cnt++;
            if (!seen_done) done_gap = cyc - last_hs;
            seen_done = 1;
         end
         if (seen_done && sif.out_valid === 1'b1) valid_after_done++;
         if (disturb && !seen_done) begin
            segs_in = SW'({$urandom(), $urandom()});
            start   = ($urandom_range(0, 3) == 0);
         end else begin
            start = 1'b0;
         end
         sif.out_ready = ($urandom_range(0, 99) < ready_pct);
         if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
            got_data.push_back(sif.out_data);
            got_sop.push_back(sif.out_sop);
            got_eop.push_back(sif.out_eop);
            got_x.push_back(dec_index_x);
            got_y.push_back(dec_index_y);
            got_seg.push_back(dec_segments);
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
         hold = (sif.out_valid === 1'b1) && (sif.out_ready === 1'b0);
         pd = sif.out_data; ps = sif.out_sop; pe = sif.out_eop;
         if (stop_after > 0 && got_data.size() == stop_after) begin
            timed_out = 0;
            start = 1'b0;
            return;
         end
         if (seen_done) post++;
         if (post == 4) begin
            timed_out = 0;
            return;
         end
      end
      start = 1'b0;
   endtask

   // Scenarios
   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; segs_in = '0; sif.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || sif.out_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle cyc=%0d busy=%b valid=%b done=%b want 0/0/0",
                     i, busy, sif.out_valid, done);
         else n_pass++;
      end
      n_checks++;
      if (dec_index_x !== 4'd0 || dec_index_y !== 2'd0)
         $display("FAIL reset_index x=%0d y=%0d want 0/0", dec_index_x, dec_index_y);
      else n_pass++;
      n_checks++;
      if (dec_segments !== 7'd0 || sif.out_data !== 8'd0 || dbg_state !== 2'd0)
         $display("FAIL reset_regs seg=%h data=%h state=%0d want 0/0/0",
                  dec_segments, sif.out_data, dbg_state);
      else n_pass++;
   endtask

   task automatic test_full_frame();
      logic [SW-1:0] snap;
      int errs, sops;
      snap = {NUM_DIGITS{7'h7F}};
      start_frame(snap);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL start_busy got=%b want=1", busy);
      else n_pass++;
      run_stream(100, 0, 0, 3000);
      n_checks++;
      if (timed_out) $display("FAIL full_timeout got=%0d bytes want=%0d", got_data.size(), FRAME);
      else n_pass++;
      n_checks++;
      if (got_data.size() != FRAME)
         $display("FAIL full_count got=%0d want=%0d", got_data.size(), FRAME);
      else n_pass++;
      errs = model_errors(snap);
      n_checks++;
      if (errs != 0) $display("FAIL full_model bad_bytes=%0d want=0", errs);
      else n_pass++;
      sops = 0;
      for (int k = 0; k < got_sop.size(); k++) if (got_sop[k] === 1'b1) sops++;
      n_checks++;
      if (sops != PAGES || got_sop[PAGE_BYTES] !== 1'b1 || got_eop[FRAME-1] !== 1'b1)
         $display("FAIL full_sop_eop sops=%0d sop96=%b eop383=%b want 4/1/1",
                  sops, got_sop[PAGE_BYTES], got_eop[FRAME-1]);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || done_gap != 1)
         $display("FAIL full_done count=%0d gap=%0d want 1/1", done_cnt, done_gap);
      else n_pass++;
      n_checks++;
      if (last_hs - first_hs != 2 * (FRAME - 1))
         $display("FAIL full_rate span=%0d want=%0d", last_hs - first_hs, 2 * (FRAME - 1));
      else n_pass++;
      exp_q = got_data;
   endtask

   task automatic test_backpressure();
      int diffs = 0;
      start_frame({NUM_DIGITS{7'h7F}});
      run_stream(50, 0, 0, 5000);
      n_checks++;
      if (timed_out || got_data.size() != exp_q.size())
         $display("FAIL bp_count got=%0d want=%0d", got_data.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < got_data.size() && k < exp_q.size(); k++)
         if (got_data[k] !== exp_q[k]) diffs++;
      n_checks++;
      if (diffs != 0) $display("FAIL bp_order diffs=%0d want=0", diffs);
      else n_pass++;
      n_checks++;
      if (stab_err != 0) $display("FAIL bp_hold unstable=%0d want=0", stab_err);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1) $display("FAIL bp_done count=%0d want=1", done_cnt);
      else n_pass++;
   endtask

   task automatic test_snapshot();
      logic [SW-1:0] snap;
      int errs;
      snap = SW'({$urandom(), $urandom()});
      start_frame(snap);
      run_stream(80, 0, 1, 5000);
      errs = model_errors(snap);
      n_checks++;
      if (timed_out || got_data.size() != FRAME)
         $display("FAIL snap_count got=%0d want=%0d", got_data.size(), FRAME);
      else n_pass++;
      n_checks++;
      if (errs != 0) $display("FAIL snap_model bad_bytes=%0d want=0", errs);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || valid_after_done != 0)
         $display("FAIL snap_single done=%0d extra_valid=%0d want 1/0", done_cnt, valid_after_done);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic [SW-1:0] snap;
      int bad = 0, errs;
      start_frame(SW'({$urandom(), $urandom()}));
      run_stream(100, 150, 0, 2000);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sif.out_valid !== 1'b1) $display("FAIL abort_pre valid=%b want=1", sif.out_valid);
      else n_pass++;
      abort = 1'b1;
      sif.out_ready = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (sif.out_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0)
         $display("FAIL abort_stop valid=%b busy=%b state=%0d want 0/0/0",
                  sif.out_valid, busy, dbg_state);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         if (done !== 1'b0 || sif.out_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      n_checks++;
      if (bad != 0) $display("FAIL abort_quiet bad_cycles=%0d want=0", bad);
      else n_pass++;
      // start and abort together in IDLE: start wins
      segs_in = '0; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || dbg_state !== 2'd1)
         $display("FAIL start_wins busy=%b state=%0d want 1/1", busy, dbg_state);
      else n_pass++;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL abort_fetch busy=%b want=0", busy);
      else n_pass++;
      snap = SW'({$urandom(), $urandom()});
      start_frame(snap);
      run_stream(60, 0, 0, 5000);
      errs = model_errors(snap);
      n_checks++;
      if (timed_out || got_data.size() != FRAME || errs != 0 || done_cnt != 1)
         $display("FAIL abort_restart bytes=%0d bad=%0d done=%0d want %0d/0/1",
                  got_data.size(), errs, done_cnt, FRAME);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [SW-1:0] snap;
      int errs;
      start_frame(SW'({$urandom(), $urandom()}));
      run_stream(100, 30, 0, 1000);
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || sif.out_valid !== 1'b0 || dec_index_x !== 4'd0 ||
          dec_index_y !== 2'd0 || dec_segments !== 7'd0)
         $display("FAIL async_reset busy=%b valid=%b x=%0d y=%0d seg=%h want all 0",
                  busy, sif.out_valid, dec_index_x, dec_index_y, dec_segments);
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      snap = SW'({$urandom(), $urandom()});
      start_frame(snap);
      run_stream(100, 0, 0, 3000);
      errs = model_errors(snap);
      n_checks++;
      if (timed_out || got_data.size() != FRAME || errs != 0)
         $display("FAIL async_restart bytes=%0d bad=%0d want %0d/0", got_data.size(), errs, FRAME);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_snapshot();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
